// File: rtl/mem_port_arb_pkg.sv
// Shared types for the unified instruction/data memory port arbiter.
// State and mode encodings plus width helpers.
package mem_port_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_ACCESS = 2'd1,
    ARB_WAIT   = 2'd2
  } arb_state_e;

  localparam logic ARB_RR    = 1'b0;
  localparam logic ARB_FIXED = 1'b1;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mem_port_arb_rr_pick.sv
// Combinational winner select for the memory port arbiter.
// Round-robin from ptr+1, or fixed lowest-index priority.
module rr_pick
  import mem_port_arb_pkg::*;
#(
  parameter int N_CH = 2,
  parameter int IW   = 1
) (
  input  logic [N_CH-1:0] req,
  input  logic [IW-1:0]   ptr,
  input  logic            fixed,
  output logic [N_CH-1:0] gnt,
  output logic [IW-1:0]   idx
);

  always_comb begin
    logic          found;
    logic [IW:0]   s;
    logic [IW-1:0] c;
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    s     = '0;
    c     = '0;
    for (int k = 0; k < N_CH; k++) begin
      s = {1'b0, ptr} + (IW+1)'(k + 1);
      if (s >= (IW+1)'(N_CH)) begin
        s = s - (IW+1)'(N_CH);
      end
      c = (fixed == ARB_FIXED) ? IW'(k) : s[IW-1:0];
      if (!found && req[c]) begin
        found  = 1'b1;
        gnt[c] = 1'b1;
        idx    = c;
      end
    end
  end

endmodule

// File: rtl/mem_port_arb.sv
// N-channel arbiter onto one shared single-port memory.
// One transaction in flight; completion routed back to the winner.
module mem_port_arb
  import mem_port_arb_pkg::*;
#(
  parameter int N_CH       = 2,
  parameter int AW         = 10,
  parameter int DW         = 32,
  parameter int MEM_LAT    = 1,
  parameter int FIXED_PRIO = 0
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic [N_CH-1:0]    req,
  input  logic [N_CH-1:0]    we,
  input  logic [N_CH*AW-1:0] addr,
  input  logic [N_CH*DW-1:0] wdata,
  output logic [N_CH-1:0]    gnt,
  output logic [N_CH-1:0]    rvalid,
  output logic [DW-1:0]      rdata,
  output logic               mem_en,
  output logic               mem_we,
  output logic [AW-1:0]      mem_addr,
  output logic [DW-1:0]      mem_wdata,
  input  logic [DW-1:0]      mem_rdata
);

  localparam int   IW   = idx_w(N_CH);
  localparam int   CW   = $clog2(MEM_LAT + 1);
  localparam logic MODE = (FIXED_PRIO != 0) ? ARB_FIXED : ARB_RR;

  arb_state_e      state_q;
  arb_state_e      state_d;
  logic [IW-1:0]   ptr_q;
  logic [IW-1:0]   win_q;
  logic [IW-1:0]   pick_idx;
  logic [N_CH-1:0] pick_gnt;
  logic [N_CH-1:0] win_oh;
  logic            we_q;
  logic [CW-1:0]   cnt_q;
  logic            done;

  rr_pick #(
    .N_CH (N_CH),
    .IW   (IW)
  ) u_pick (
    .req   (req),
    .ptr   (ptr_q),
    .fixed (MODE),
    .gnt   (pick_gnt),
    .idx   (pick_idx)
  );

  assign done   = (state_q == ARB_WAIT) && (cnt_q == '0);
  assign win_oh = N_CH'(1) << win_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ARB_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Snapshot taken in IDLE; later req/addr changes do not affect the issue.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ptr_q     <= IW'(N_CH - 1);
      win_q     <= '0;
      we_q      <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      cnt_q     <= '0;
    end else begin
      if (state_q == ARB_IDLE && |pick_gnt) begin
        win_q     <= pick_idx;
        we_q      <= we[pick_idx];
        mem_addr  <= addr[pick_idx*AW +: AW];
        mem_wdata <= wdata[pick_idx*DW +: DW];
        if (MODE == ARB_RR) begin
          ptr_q <= pick_idx;
        end
      end
      if (state_q == ARB_ACCESS) begin
        cnt_q <= CW'(MEM_LAT - 1);
      end else if (state_q == ARB_WAIT && cnt_q != '0) begin
        cnt_q <= cnt_q - CW'(1);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ARB_IDLE:   if (|pick_gnt) state_d = ARB_ACCESS;
      ARB_ACCESS: state_d = ARB_WAIT;
      ARB_WAIT:   if (cnt_q == '0) state_d = ARB_IDLE;
      default:    state_d = ARB_IDLE;
    endcase
  end

  always_comb begin
    gnt    = '0;
    rvalid = '0;
    rdata  = '0;
    mem_en = 1'b0;
    mem_we = 1'b0;
    unique case (1'b1)
      (state_q == ARB_ACCESS): begin
        gnt    = win_oh;
        mem_en = 1'b1;
        mem_we = we_q;
      end
      done: begin
        rvalid = win_oh;
        rdata  = we_q ? '0 : mem_rdata;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_port_arb.sv
// Directed bench for mem_port_arb: RR 2-ch lat 1, and fixed 4-ch lat 4.
// Completions are checked against a scoreboard filled at grant time.
module tb_mem_port_arb;

  localparam int LAT_A = 1;
  localparam int LAT_B = 4;

  typedef struct {
    int          ch;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  logic clk;
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;

  exp_t sb_a[$];
  exp_t sb_b[$];
  int   gcyc_a;
  int   gcyc_b;
  int   prev;

  logic        rstn_a;
  logic [1:0]  req_a, we_a, gnt_a, rvalid_a;
  logic [19:0] addr_a;
  logic [63:0] wdata_a;
  logic [31:0] rdata_a, mem_wdata_a, mem_rdata_a;
  logic        mem_en_a, mem_we_a;
  logic [9:0]  mem_addr_a;

  logic        rstn_b;
  logic [3:0]  req_b, we_b, gnt_b, rvalid_b;
  logic [39:0] addr_b;
  logic [127:0] wdata_b;
  logic [31:0] rdata_b, mem_wdata_b, mem_rdata_b;
  logic        mem_en_b, mem_we_b;
  logic [9:0]  mem_addr_b;

  logic        pipe_a;
  logic [3:0]  pipe_b;
  logic        wr_seen_a;
  logic [9:0]  wr_addr_a;
  logic [31:0] wr_data_a;

  mem_port_arb #(
    .N_CH(2), .AW(10), .DW(32), .MEM_LAT(LAT_A), .FIXED_PRIO(0)
  ) u_a (
    .clk(clk), .rstn(rstn_a), .req(req_a), .we(we_a),
    .addr(addr_a), .wdata(wdata_a), .gnt(gnt_a),
    .rvalid(rvalid_a), .rdata(rdata_a), .mem_en(mem_en_a),
    .mem_we(mem_we_a), .mem_addr(mem_addr_a),
    .mem_wdata(mem_wdata_a), .mem_rdata(mem_rdata_a)
  );

  mem_port_arb #(
    .N_CH(4), .AW(10), .DW(32), .MEM_LAT(LAT_B), .FIXED_PRIO(1)
  ) u_b (
    .clk(clk), .rstn(rstn_b), .req(req_b), .we(we_b),
    .addr(addr_b), .wdata(wdata_b), .gnt(gnt_b),
    .rvalid(rvalid_b), .rdata(rdata_b), .mem_en(mem_en_b),
    .mem_we(mem_we_b), .mem_addr(mem_addr_b),
    .mem_wdata(mem_wdata_b), .mem_rdata(mem_rdata_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  function automatic logic [31:0] rd(input logic [9:0] a);
    return (a == 10'h155) ? 32'hDEADBEEF : (32'hC0DE_0000 ^ {22'd0, a});
  endfunction

  // Memory model: read data only valid exactly MEM_LAT cycles after mem_en.
  always @(posedge clk) begin
    if (!rstn_a) begin
      pipe_a    <= 1'b0;
      wr_seen_a <= 1'b0;
      wr_addr_a <= '0;
      wr_data_a <= '0;
    end else begin
      pipe_a <= mem_en_a & ~mem_we_a;
      if (mem_en_a && mem_we_a) begin
        wr_seen_a <= 1'b1;
        wr_addr_a <= mem_addr_a;
        wr_data_a <= mem_wdata_a;
      end
    end
  end

  always @(posedge clk) begin
    if (!rstn_b) pipe_b <= '0;
    else pipe_b <= {pipe_b[2:0], mem_en_b & ~mem_we_b};
  end

  assign mem_rdata_a = !pipe_a ? 32'hBAD0_BAD0 :
    (wr_seen_a && wr_addr_a == mem_addr_a) ? wr_data_a : rd(mem_addr_a);
  assign mem_rdata_b = pipe_b[3] ? rd(mem_addr_b) : 32'hBAD0_BAD0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp_v);
    tests++;
    assert (obs === exp_v) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic chk_rst_a(input string tag);
    chk({tag, "_gnt"}, 32'(gnt_a), 32'd0);
    chk({tag, "_rvalid"}, 32'(rvalid_a), 32'd0);
    chk({tag, "_rdata"}, rdata_a, 32'd0);
    chk({tag, "_en_we"}, 32'({mem_en_a, mem_we_a}), 32'd0);
    chk({tag, "_addr"}, 32'(mem_addr_a), 32'd0);
    chk({tag, "_wdata"}, mem_wdata_a, 32'd0);
  endtask

  task automatic chk_rst_b(input string tag);
    chk({tag, "_gnt"}, 32'(gnt_b), 32'd0);
    chk({tag, "_rvalid"}, 32'(rvalid_b), 32'd0);
    chk({tag, "_rdata"}, rdata_b, 32'd0);
    chk({tag, "_en_we"}, 32'({mem_en_b, mem_we_b}), 32'd0);
    chk({tag, "_addr"}, 32'(mem_addr_b), 32'd0);
    chk({tag, "_wdata"}, mem_wdata_b, 32'd0);
  endtask

  task automatic wait_gnt_a(input logic [1:0] expg, input string tag);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (gnt_a == '0 && n < 20);
    chk(tag, 32'(gnt_a), 32'(expg));
    gcyc_a = cyc;
  endtask

  task automatic wait_gnt_b(input logic [3:0] expg, input string tag);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (gnt_b == '0 && n < 30);
    chk(tag, 32'(gnt_b), 32'(expg));
    gcyc_b = cyc;
  endtask

  task automatic push_a(input int ch, input logic [31:0] d);
    exp_t e;
    e.ch = ch; e.data = d; e.cyc = gcyc_a + LAT_A;
    sb_a.push_back(e);
  endtask

  task automatic push_b(input int ch, input logic [31:0] d);
    exp_t e;
    e.ch = ch; e.data = d; e.cyc = gcyc_b + LAT_B;
    sb_b.push_back(e);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rvalid_a != '0) begin
      if (sb_a.size() == 0) begin
        chk("a_spurious_rvalid", 32'(rvalid_a), 32'd0);
      end else begin
        e = sb_a.pop_front();
        chk("a_rvalid_ch", 32'(rvalid_a), 32'd1 << e.ch);
        chk("a_rdata", rdata_a, e.data);
        chk("a_rvalid_cyc", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (rvalid_b != '0) begin
      if (sb_b.size() == 0) begin
        chk("b_spurious_rvalid", 32'(rvalid_b), 32'd0);
      end else begin
        e = sb_b.pop_front();
        chk("b_rvalid_ch", 32'(rvalid_b), 32'd1 << e.ch);
        chk("b_rdata", rdata_b, e.data);
        chk("b_rvalid_cyc", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  initial begin
    rstn_a = 1'b0;
    rstn_b = 1'b0;
    req_a = '0; we_a = '0; addr_a = '0; wdata_a = '0;
    req_b = '0; we_b = '0; addr_b = '0; wdata_b = '0;

    repeat (3) begin
      @(negedge clk);
      req_a   = 2'($urandom);
      we_a    = 2'($urandom);
      addr_a  = 20'($urandom);
      wdata_a = {$urandom, $urandom};
      req_b   = 4'($urandom);
      we_b    = 4'($urandom);
      addr_b  = {8'($urandom), $urandom};
      wdata_b = {$urandom, $urandom, $urandom, $urandom};
      #1;
      chk_rst_a("a_rst");
      chk_rst_b("b_rst");
    end

    // Instance A: round-robin, both channels held.
    @(negedge clk);
    req_a  = 2'b11;
    we_a   = 2'b00;
    addr_a = {10'h155, 10'h010};
    rstn_a = 1'b1;

    wait_gnt_a(2'b01, "a_first_gnt");
    chk("a_g1_addr", 32'(mem_addr_a), 32'h010);
    chk("a_g1_en_we", 32'({mem_en_a, mem_we_a}), 32'b10);
    push_a(0, rd(10'h010));
    prev = gcyc_a;

    wait_gnt_a(2'b10, "a_rr_gnt2");
    chk("a_rr_space2", 32'(gcyc_a - prev), 32'(LAT_A + 2));
    chk("a_g2_addr", 32'(mem_addr_a), 32'h155);
    chk("a_g2_en_we", 32'({mem_en_a, mem_we_a}), 32'b10);
    push_a(1, 32'hDEADBEEF);
    prev = gcyc_a;

    wait_gnt_a(2'b01, "a_rr_gnt3");
    chk("a_rr_space3", 32'(gcyc_a - prev), 32'(LAT_A + 2));
    push_a(0, rd(10'h010));
    prev = gcyc_a;

    wait_gnt_a(2'b10, "a_rr_gnt4");
    chk("a_rr_space4", 32'(gcyc_a - prev), 32'(LAT_A + 2));
    push_a(1, 32'hDEADBEEF);
    req_a = 2'b00;

    // Write on ch0, then read it back through ch1.
    we_a    = 2'b01;
    addr_a  = {10'h000, 10'h3FC};
    wdata_a = {32'h0, 32'h12345678};
    req_a   = 2'b01;
    wait_gnt_a(2'b01, "a_wr_gnt");
    chk("a_wr_en_we", 32'({mem_en_a, mem_we_a}), 32'b11);
    chk("a_wr_addr", 32'(mem_addr_a), 32'h3FC);
    chk("a_wr_wdata", mem_wdata_a, 32'h12345678);
    push_a(0, 32'h0);
    req_a = 2'b00;
    we_a  = 2'b00;
    @(negedge clk);
    chk("a_wr_one_cycle", 32'({mem_en_a, mem_we_a}), 32'b00);

    addr_a = {10'h3FC, 10'h000};
    req_a  = 2'b10;
    wait_gnt_a(2'b10, "a_rdback_gnt");
    push_a(1, 32'h12345678);
    prev = gcyc_a;

    // Late request waits; inputs changing after acceptance do not leak.
    req_a  = 2'b01;
    addr_a = {10'h000, 10'h0AA};
    @(negedge clk);
    chk("a_snapshot_addr", 32'(mem_addr_a), 32'h3FC);
    wait_gnt_a(2'b01, "a_late_gnt");
    chk("a_late_space", 32'(gcyc_a - prev), 32'(LAT_A + 2));
    push_a(0, rd(10'h0AA));
    req_a = 2'b00;
    repeat (4) @(negedge clk);

    // Instance B: fixed priority, ch1/ch3 starve behind ch0.
    req_b   = 4'b1011;
    we_b    = 4'b0000;
    addr_b  = {10'h023, 10'h022, 10'h021, 10'h020};
    wdata_b = '0;
    rstn_b  = 1'b1;

    wait_gnt_b(4'b0001, "b_fix_gnt1");
    push_b(0, rd(10'h020));
    prev = gcyc_b;
    for (int i = 0; i < 2; i++) begin
      wait_gnt_b(4'b0001, "b_fix_gnt_ch0");
      chk("b_fix_space", 32'(gcyc_b - prev), 32'(LAT_B + 2));
      push_b(0, rd(10'h020));
      prev = gcyc_b;
    end
    req_b = 4'b1010;
    wait_gnt_b(4'b0010, "b_drop0_ch1");
    chk("b_ch1_addr", 32'(mem_addr_b), 32'h021);
    push_b(1, rd(10'h021));
    req_b = 4'b1000;
    wait_gnt_b(4'b1000, "b_ch3");
    push_b(3, rd(10'h023));

    // Reset two cycles into a transaction: abandoned, then re-granted.
    req_b  = 4'b0001;
    addr_b = {10'h023, 10'h022, 10'h021, 10'h030};
    wait_gnt_b(4'b0001, "b_pre_rst_gnt");
    @(negedge clk);
    @(negedge clk);
    rstn_b = 1'b0;
    #1;
    chk_rst_b("b_midrst");
    @(negedge clk);
    chk_rst_b("b_midrst2");
    rstn_b = 1'b1;
    wait_gnt_b(4'b0001, "b_regrant");
    chk("b_regrant_addr", 32'(mem_addr_b), 32'h030);
    push_b(0, rd(10'h030));
    req_b = 4'b0000;
    repeat (8) @(negedge clk);

    chk("a_sb_empty", 32'(sb_a.size()), 32'd0);
    chk("b_sb_empty", 32'(sb_b.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
